// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: a fixed-latency multiply and a WIDTH-step
// restoring divide, with the results in hi/lo and an abort input (flush).
module muldiv_seq #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, SIGN} state_t;

  state_t               r_state, w_nxt;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_x, r_y, r_quo, r_rem;
  logic                 r_sgn, r_dbz, r_qneg, r_rneg, r_done, r_dz;
  logic                 w_accept, w_complete;
  logic [2*WIDTH-1:0]   w_xe, w_ye, w_prod;
  logic [WIDTH:0]       w_sh, w_sub;
  logic [WIDTH-1:0]     w_xabs, w_yabs;

  assign w_xe   = {{WIDTH{r_sgn & r_x[WIDTH-1]}}, r_x};
  assign w_ye   = {{WIDTH{r_sgn & r_y[WIDTH-1]}}, r_y};
  assign w_prod = w_xe * w_ye;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign w_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_sub = w_sh - {1'b0, r_y};

  assign w_xabs = (op[0] && X[WIDTH-1]) ? -X : X;
  assign w_yabs = (op[0] && Y[WIDTH-1]) ? -Y : Y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (flush) w_nxt = IDLE;
    else begin
      case (r_state)
        IDLE:    if (start) w_nxt = !op[1] ? MUL : ((Y == '0) ? SIGN : DIV);
        MUL:     if (r_cnt == CW'(MUL_LAT - 1)) w_nxt = IDLE;
        DIV:     if (r_cnt == CW'(WIDTH - 1)) w_nxt = SIGN;
        SIGN:    w_nxt = IDLE;
        default: w_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (r_state != IDLE);
    w_accept   = (r_state == IDLE) && start && !flush;
    w_complete = !flush && (((r_state == MUL) && (r_cnt == CW'(MUL_LAT - 1))) ||
                            (r_state == SIGN));
  end

  assign done        = r_done;
  assign div_by_zero = r_dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_sgn  <= 1'b0;
      r_dbz  <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      r_done <= w_complete;
      if (w_accept) begin
        // Divides keep magnitudes; the sign fix-up happens in SIGN.
        r_x    <= X;
        r_y    <= op[1] ? w_yabs : Y;
        r_quo  <= w_xabs;
        r_rem  <= '0;
        r_cnt  <= '0;
        r_sgn  <= op[0];
        r_dbz  <= op[1] && (Y == '0);
        r_qneg <= op[0] & (X[WIDTH-1] ^ Y[WIDTH-1]);
        r_rneg <= op[0] & X[WIDTH-1];
        r_dz   <= 1'b0;
      end else if (!flush) begin
        case (r_state)
          MUL: r_cnt <= r_cnt + 1'b1;
          DIV: begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_sub[WIDTH]) begin
              r_rem <= w_sub[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= w_sh[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
      if (w_complete) begin
        if (r_state == MUL) begin
          {hi, lo} <= w_prod;
        end else if (r_dbz) begin
          hi   <= r_x;
          lo   <= '1;
          r_dz <= 1'b1;
        end else begin
          lo <= r_qneg ? -r_quo : r_quo;
          hi <= r_rneg ? -r_rem : r_rem;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results come from plain integer
// arithmetic and are checked by an independent negedge monitor.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] X, Y;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        me;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_hi = '0, last_lo = '0;
  logic        last_dbz = 1'b0;

  muldiv_seq #(.WIDTH(32), .MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .X(X), .Y(Y),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input int c0);
    exp_t   e;
    logic [63:0] p;
    longint sx, sy, q, r;
    e.dbz = 1'b0;
    case (o)
      2'b00: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; e.due = c0 + 4; end
      2'b01: begin
        sx = longint'($signed(x)); sy = longint'($signed(y));
        q = sx * sy; p = q; e.hi = p[63:32]; e.lo = p[31:0]; e.due = c0 + 4;
      end
      default: begin
        if (y == 0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = x; e.dbz = 1'b1; e.due = c0 + 1;
        end else begin
          if (o[0]) begin sx = longint'($signed(x)); sy = longint'($signed(y)); end
          else begin sx = longint'({32'b0, x}); sy = longint'({32'b0, y}); end
          q = sx / sy; r = sx % sy;
          p = q; e.lo = p[31:0];
          p = r; e.hi = p[31:0];
          e.due = c0 + 33;
        end
      end
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Call only with busy low; the start is taken on the next rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; X = x; Y = y;
    tick();
    start = 1'b0; X = $urandom; Y = $urandom; op = 2'($urandom_range(0, 3));
    chk("dbz_cleared_at_accept", div_by_zero, 0);
    sbq.push_back(model(o, x, y, cyc));
    last_dbz = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("idle_timeout", busy, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sbq.size() == 0) chk("spurious_done", done, 0);
        else begin
          me = sbq.pop_front();
          chk("done_cycle", cyc, me.due);
          chk("hi", hi, me.hi);
          chk("lo", lo, me.lo);
          chk("div_by_zero", div_by_zero, me.dbz);
          chk("busy_in_done", busy, 0);
          last_hi = me.hi; last_lo = me.lo; last_dbz = me.dbz;
        end
      end else begin
        chk("busy", busy, sbq.size() != 0);
        chk("hold_hi", hi, last_hi);
        chk("hold_lo", lo, last_lo);
        chk("hold_dbz", div_by_zero, last_dbz);
        if (sbq.size() != 0 && cyc > sbq[0].due) begin
          chk("late_done", done, 1);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] x, y;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; X = '0; Y = '0;
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases, issued back-to-back in each done cycle.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    issue(2'b01, 32'hFFFF_FFFD, 32'd5);         wait_idle();
    issue(2'b10, 32'd100, 32'd7);               wait_idle();
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);         wait_idle();
    issue(2'b11, 32'h1234_5678, 32'd0);         wait_idle();
    issue(2'b10, 32'd12345, 32'd0);             wait_idle();
    issue(2'b00, 32'd3, 32'd4);                 wait_idle();
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(2'b11, 32'd7, 32'hFFFF_FFFE);         wait_idle();

    // Flush during the 10th cycle of a divu; a start alongside it is ignored.
    issue(2'b10, 32'd1000, 32'd3);
    repeat (9) tick();
    flush = 1'b1; start = 1'b1; op = 2'b00;
    tick();
    flush = 1'b0; start = 1'b0;
    sbq.delete();
    chk("flush_busy", busy, 0);
    tick();
    chk("flush_stays_idle", busy, 0);

    // A start while busy must not be taken.
    issue(2'b10, 32'hDEAD_BEEF, 32'd13);
    repeat (5) tick();
    start = 1'b1; op = 2'b00;
    tick();
    start = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a multiply.
    issue(2'b01, 32'h7FFF_0001, 32'h0000_1234);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_done", done, 0);
    chk("arst_hi", hi, 0); chk("arst_lo", lo, 0); chk("arst_dbz", div_by_zero, 0);
    sbq.delete();
    last_hi = '0; last_lo = '0; last_dbz = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    issue(2'b00, 32'd6, 32'd7); wait_idle();

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'hFFFF_FFFF;
        default: y = 32'($urandom);
      endcase
      issue(o, x, y);
      wait_idle();
    end

    repeat (3) tick();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width.
REQ-002 The block SHALL have parameter MUL_LAT, default 4, giving the multiply latency in cycles (legal range 1..8).
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start SHALL be an input, 1 bit: request to begin an operation.
REQ-006 Port op SHALL be an input, 2 bits: 00 multu, 01 mult, 10 divu, 11 div.
REQ-007 Ports X and Y SHALL be inputs, WIDTH bits each: multiplicand/dividend and multiplier/divisor.
REQ-008 Port flush SHALL be an input, 1 bit: abort of the in-flight operation.
REQ-009 Port busy SHALL be an output, 1 bit: an operation is in flight; the pipeline stalls on it.
REQ-010 Port done SHALL be an output, 1 bit: one-cycle pulse marking new hi/lo results.
REQ-011 Ports hi and lo SHALL be outputs, WIDTH bits each: the result registers.
REQ-012 Port div_by_zero SHALL be an output, 1 bit: the last completed divide had Y==0.

Function
REQ-013 The state machine SHALL have states IDLE, MUL, DIV, SIGN.
REQ-014 A request SHALL be accepted on a rising edge (E0) where start=1, flush=0 and state is IDLE; X, Y and op SHALL be captured at E0.
REQ-015 start SHALL be ignored while busy=1; no queuing.
REQ-016 busy SHALL be 1 in every cycle from after E0 until state returns to IDLE, and 0 otherwise.
REQ-017 multu/mult SHALL enter MUL; {hi,lo} SHALL be loaded with the 2*WIDTH-bit unsigned/signed product at edge E(MUL_LAT); then state SHALL return to IDLE.
REQ-018 divu/div with Y!=0 SHALL enter DIV and run WIDTH restoring shift-subtract iterations on operand magnitudes (one per edge, E1..E(WIDTH)), counted by an internal counter.
REQ-019 After the last iteration the block SHALL enter SIGN; at E(WIDTH+1) it SHALL load lo=quotient and hi=remainder, then return to IDLE.
REQ-020 Signed division SHALL truncate toward zero: the quotient is negated when operand signs differ, and the remainder takes the sign of the dividend.
REQ-021 Signed overflow (X=0x80000000, Y=0xFFFFFFFF) SHALL give lo=0x80000000, hi=0 with no special state.
REQ-022 A divide with Y==0 SHALL skip DIV and load lo=all ones and hi=X at E1; div_by_zero SHALL be set at E1.
REQ-023 div_by_zero SHALL hold its value until the next accepted request clears it at E0.
REQ-024 done SHALL be 1 for exactly the one cycle after the edge that loads hi/lo; busy SHALL be 0 in that cycle, so a new start can be accepted then.
REQ-025 hi and lo SHALL change only on a completion edge or on reset.
REQ-026 flush=1 on any edge SHALL force IDLE, suppress done and leave hi, lo and div_by_zero unchanged.
REQ-027 flush SHALL take priority over start and over completion on the same edge.

Reset
REQ-028 While rst_n=0, the block SHALL immediately set state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, and clear the iteration counter and captured operands.
REQ-029 Reset SHALL abort an in-flight operation with no done pulse.
REQ-030 The first accepted start SHALL be on the first rising edge with rst_n=1.

Verification
REQ-031 The bench SHALL check: multu X=0xFFFFFFFF, Y=0xFFFFFFFF -> at E4, hi=0xFFFFFFFE and lo=0x00000001; done high for one cycle; busy high for 4 cycles.
REQ-032 The bench SHALL check: mult X=0xFFFFFFFD (-3), Y=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 The bench SHALL check: divu 100/7 -> lo=14, hi=2 at E33; and div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 The bench SHALL check: div X=0x12345678, Y=0 -> at E1, lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1; the next accepted start clears div_by_zero.
REQ-035 The bench SHALL check: flush at cycle 10 of a divu -> IDLE next cycle, busy=0, no done, hi/lo keep prior values; a start in that same cycle is ignored.
REQ-036 The bench SHALL check: rst_n low mid-MUL -> all outputs 0 asynchronously; back-to-back start in the done cycle is accepted.
